decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: if_valid  in  1 / if_inst  in  32 / if_pc  in  32, the fetch offer.
REQ-004 SHALL have ports: if_ready  out  1, decode accepts the offer this cycle.
REQ-005 SHALL have ports: stall_i  in  1 (load-use hold from register file) / flush_x  in  1 (taken branch/jump in X).
REQ-006 SHALL have register-file ports (all combinational from the D register): rs1, rs2, rd  out  5 each; rs1_v, rs2_v, rdx_v, rdm_v  out  1 each.
REQ-007 SHALL have X-side ports (registered): x_valid  1, x_pc  32, x_imm  32, x_alu_op  alu_op_t, x_funct3  3, x_is_load / x_is_store / x_is_branch / x_is_jal / x_is_jalr / x_illegal  1 each.

Function
REQ-008 SHALL hold one instruction in the D register (d_valid, d_inst, d_pc); an offer is accepted on an edge where if_valid & if_ready.
REQ-009 SHALL drive if_ready = !stall_i | !d_valid.
REQ-010 SHALL drive rs1/rs2/rd from d_inst[19:15]/[24:20]/[11:7] every cycle, including while stalled, so that the register file re-reads the sources.
REQ-011 SHALL drive rs1_v/rs2_v = d_valid & !flush_x & (format uses the field) & (field != 0).
REQ-012 SHALL drive rdm_v = d_valid & !flush_x & (format writes rd) & (rd != 0) & !illegal.
REQ-013 SHALL drive rdx_v = rdm_v & (opcode in OP, OP-IMM, LUI, AUIPC, JAL, JALR) & !(OP with funct7 = 0000001); loads and M-extension ops give rdx_v=0, rdm_v=1.
REQ-014 SHALL compute x_imm by sign extension per I/S/B/U/J format; U-format produces {inst[31:12], 12'b0}; R-format produces 0.
REQ-015 SHALL flag x_illegal on an unknown opcode, or a reserved funct3/funct7 for the decoded opcode; an illegal instruction drives all *_v outputs to 0.
REQ-016 SHALL have latency: instruction accepted at edge N, decoded on x_* after edge N+1.
REQ-017 SHALL, on stall_i=1, hold the D register and all x_* registers unchanged.
REQ-018 SHALL, on flush_x=1, clear d_valid and x_valid at the next edge; flush_x SHALL win over stall_i and over a simultaneous accept (the offered instruction is dropped).
REQ-019 SHALL, with d_valid=0 and no stall, load x_valid=0 (bubble); the other x_* registers are don't-care.

Reset
REQ-020 SHALL, on rst_n low, immediately clear d_valid and x_valid and all x_is_* / x_illegal; x_pc, x_imm, x_alu_op and x_funct3 SHALL reset to 0.
REQ-021 SHALL, during reset, hold if_ready=1 and all *_v outputs at 0; an instruction in flight when reset asserts is discarded.

Configuration
REQ-022 SHALL use macro RV32M_EN: defined -> OP with funct7=0000001 decodes as MUL/DIV family (alu_op_t M codes, rdm_v=1, rdx_v=0); undefined -> such encodings set x_illegal=1.

Structure
REQ-023 SHALL take opcode constants, the alu_op_t enum and the funct7 constants from the shared package riscv_pkg.
REQ-024 SHALL implement immediate extraction as the sub-module imm_gen (combinational: inst -> imm, fmt).

Verification
REQ-025 Test: addi x5,x0,7 (0x00700293) -> rd=5, rs1_v=0, rs2_v=0, rdx_v=1, rdm_v=1; next cycle x_imm=0x00000007, x_valid=1.
REQ-026 Test: lw x6,4(x5) (0x0042A303) -> rs1=5, rs1_v=1, rdx_v=0, rdm_v=1, x_is_load=1, x_imm=4.
REQ-027 Test: mul x7,x5,x6 (0x026283B3) -> with RV32M_EN: rdm_v=1, rdx_v=0, x_illegal=0; without: x_illegal=1, all *_v=0.
REQ-028 Test: beq x5,x6,-8 (0xFE628CE3) -> rs1_v=rs2_v=1, rdm_v=0, x_is_branch=1, x_imm=0xFFFFFFF8.
REQ-029 Test: stall_i=1 for 2 cycles with D holding lw -> if_ready=0, rs1=5 held, x_* unchanged; the instruction advances on the first edge with stall_i=0.
REQ-030 Test: flush_x=1 together with stall_i=1 and if_valid=1 -> next cycle d_valid=0, x_valid=0, the offered instruction is not decoded; rst_n low mid-stream -> x_valid=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 opcode/funct7 constants, ALU op and immediate-format enums, X-stage bundle
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic [2:0]  funct3;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
    } x_bundle_t;

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
    function automatic alu_op_t base_alu_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_t muldiv_alu_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-to-decode offer/accept handshake
interface decode_stage_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (output if_valid, if_inst, if_pc, input if_ready);
    modport slave  (input if_valid, if_inst, if_pc, output if_ready);
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate extraction and format classification from the opcode
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o,
    output fmt_t        fmt_o
);

    fmt_t fmt;

    always_comb begin
        fmt = FMT_R;
        case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            default:                        fmt = FMT_R;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (fmt)
            FMT_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U: imm_o = {inst_i[31:12], 12'b0};
            FMT_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - D stage: one-entry instruction holder, register-file read requests, registered X decode
// RV32M_EN: when defined, OP with funct7=0000001 decodes as MUL/DIV; otherwise it is illegal.
module decode_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave fetch,
    input  logic          stall_i,
    input  logic          flush_x,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic [4:0]    rd,
    output logic          rs1_v,
    output logic          rs2_v,
    output logic          rdx_v,
    output logic          rdm_v,
    output logic          x_valid,
    output logic [31:0]   x_pc,
    output logic [31:0]   x_imm,
    output alu_op_t       x_alu_op,
    output logic [2:0]    x_funct3,
    output logic          x_is_load,
    output logic          x_is_store,
    output logic          x_is_branch,
    output logic          x_is_jal,
    output logic          x_is_jalr,
    output logic          x_illegal
);

    logic        d_valid_q, d_valid_d;
    logic [31:0] d_inst_q, d_inst_d;
    logic [31:0] d_pc_q, d_pc_d;
    x_bundle_t   x_q, x_d, x_next;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm;
    fmt_t        fmt;
    alu_op_t     alu_op;
    logic        illegal, is_muldiv, live, fast_wb, accept;

    assign opcode = d_inst_q[6:0];
    assign funct3 = d_inst_q[14:12];
    assign funct7 = d_inst_q[31:25];

    imm_gen u_imm_gen (
        .inst_i (d_inst_q),
        .imm_o  (imm),
        .fmt_o  (fmt)
    );

    always_comb begin
        illegal = 1'b0;
        alu_op  = ALU_ADD;
        case (opcode)
            OPC_LUI:            alu_op = ALU_PASS_B;
            OPC_AUIPC, OPC_JAL: alu_op = ALU_ADD;
            OPC_JALR:           illegal = (funct3 != 3'b000);
            OPC_BRANCH: begin
                alu_op  = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD:  illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            OPC_STORE: illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
            OPC_OP_IMM: begin
                alu_op = base_alu_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b001)
                    illegal = (funct7 != F7_BASE);
                else if (funct3 == 3'b101)
                    illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
            end
            OPC_OP: begin
                if (funct7 == F7_BASE)
                    alu_op = base_alu_op(funct3, 1'b0);
                else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                    alu_op = base_alu_op(funct3, 1'b1);
                else if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    alu_op = muldiv_alu_op(funct3);
`else
                    illegal = 1'b1;
`endif
                end else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Register-file requests: an illegal or flushed instruction requests nothing
    assign is_muldiv = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    assign fast_wb   = (opcode inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR}) && !is_muldiv;
    assign live      = d_valid_q && !flush_x && !illegal;

    assign rs1   = d_inst_q[19:15];
    assign rs2   = d_inst_q[24:20];
    assign rd    = d_inst_q[11:7];
    assign rs1_v = live && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) && (rs1 != 5'd0);
    assign rs2_v = live && (fmt inside {FMT_R, FMT_S, FMT_B}) && (rs2 != 5'd0);
    assign rdm_v = live && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (rd != 5'd0);
    assign rdx_v = rdm_v && fast_wb;

    always_comb begin
        x_next           = '0;
        x_next.valid     = d_valid_q;
        x_next.pc        = d_pc_q;
        x_next.imm       = imm;
        x_next.alu_op    = alu_op;
        x_next.funct3    = funct3;
        x_next.is_load   = d_valid_q && !illegal && (opcode == OPC_LOAD);
        x_next.is_store  = d_valid_q && !illegal && (opcode == OPC_STORE);
        x_next.is_branch = d_valid_q && !illegal && (opcode == OPC_BRANCH);
        x_next.is_jal    = d_valid_q && !illegal && (opcode == OPC_JAL);
        x_next.is_jalr   = d_valid_q && !illegal && (opcode == OPC_JALR);
        x_next.illegal   = d_valid_q && illegal;
    end

    assign fetch.if_ready = !stall_i || !d_valid_q;
    assign accept         = fetch.if_valid && fetch.if_ready;

    // Flush beats stall and a same-cycle accept; an empty D may still fill under stall
    always_comb begin
        d_valid_d = d_valid_q;
        d_inst_d  = d_inst_q;
        d_pc_d    = d_pc_q;
        x_d       = x_q;
        if (flush_x) begin
            d_valid_d = 1'b0;
            x_d.valid = 1'b0;
        end else begin
            if (!stall_i)
                x_d = x_next;
            if (accept) begin
                d_valid_d = 1'b1;
                d_inst_d  = fetch.if_inst;
                d_pc_d    = fetch.if_pc;
            end else if (!stall_i) begin
                d_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q <= 1'b0;
            d_inst_q  <= '0;
            d_pc_q    <= '0;
            x_q       <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_inst_q  <= d_inst_d;
            d_pc_q    <= d_pc_d;
            x_q       <= x_d;
        end
    end

    assign x_valid     = x_q.valid;
    assign x_pc        = x_q.pc;
    assign x_imm       = x_q.imm;
    assign x_alu_op    = x_q.alu_op;
    assign x_funct3    = x_q.funct3;
    assign x_is_load   = x_q.is_load;
    assign x_is_store  = x_q.is_store;
    assign x_is_branch = x_q.is_branch;
    assign x_is_jal    = x_q.is_jal;
    assign x_is_jalr   = x_q.is_jalr;
    assign x_illegal   = x_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized bench for decode_stage against a behavioural decode model
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk, rst_n, stall_i, flush_x;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_v, rs2_v, rdx_v, rdm_v;
    logic        x_valid;
    logic [31:0] x_pc, x_imm;
    alu_op_t     x_alu_op;
    logic [2:0]  x_funct3;
    logic        x_is_load, x_is_store, x_is_branch, x_is_jal, x_is_jalr, x_illegal;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    decode_stage_if fetch_if ();

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch_if), .stall_i(stall_i), .flush_x(flush_x),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_v(rs1_v), .rs2_v(rs2_v), .rdx_v(rdx_v), .rdm_v(rdm_v),
        .x_valid(x_valid), .x_pc(x_pc), .x_imm(x_imm), .x_alu_op(x_alu_op), .x_funct3(x_funct3),
        .x_is_load(x_is_load), .x_is_store(x_is_store), .x_is_branch(x_is_branch),
        .x_is_jal(x_is_jal), .x_is_jalr(x_is_jalr), .x_illegal(x_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        legal, r1, r2, wd, fast, ld, st, br, jal, jalr;
        logic [31:0] imm;
        alu_op_t     alu;
    } ref_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        int sh;
        sh = 32 - bits;
        return 32'($signed(v << sh) >>> sh);
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        alu_op_t base_tab [8];
        alu_op_t md_tab [8];
        base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        md_tab   = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        d = '0;
        d.alu = ALU_ADD;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h37: begin d.legal = 1; d.wd = 1; d.fast = 1; d.imm = {w[31:12], 12'h000}; d.alu = ALU_PASS_B; end
            7'h17: begin d.legal = 1; d.wd = 1; d.fast = 1; d.imm = {w[31:12], 12'h000}; end
            7'h6F: begin
                d.legal = 1; d.wd = 1; d.fast = 1; d.jal = 1;
                d.imm = sx({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            end
            7'h67: begin
                d.legal = (f3 == 3'd0); d.r1 = 1; d.wd = 1; d.fast = 1; d.jalr = 1;
                d.imm = sx({20'b0, w[31:20]}, 12);
            end
            7'h63: begin
                d.legal = (f3 != 3'd2) && (f3 != 3'd3); d.r1 = 1; d.r2 = 1; d.br = 1; d.alu = ALU_SUB;
                d.imm = sx({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            end
            7'h03: begin
                d.legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); d.r1 = 1; d.wd = 1; d.ld = 1;
                d.imm = sx({20'b0, w[31:20]}, 12);
            end
            7'h23: begin
                d.legal = (f3 < 3'd3); d.r1 = 1; d.r2 = 1; d.st = 1;
                d.imm = sx({20'b0, w[31:25], w[11:7]}, 12);
            end
            7'h13: begin
                d.r1 = 1; d.wd = 1; d.fast = 1; d.imm = sx({20'b0, w[31:20]}, 12);
                d.alu = base_tab[f3];
                if (f3 == 3'd1) d.legal = (f7 == 7'h00);
                else if (f3 == 3'd5) begin
                    d.legal = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) d.alu = ALU_SRA;
                end else d.legal = 1;
            end
            7'h33: begin
                d.r1 = 1; d.r2 = 1; d.wd = 1; d.fast = (f7 != 7'h01);
                if (f7 == 7'h00) begin d.legal = 1; d.alu = base_tab[f3]; end
                else if (f7 == 7'h20) begin
                    d.legal = (f3 == 3'd0) || (f3 == 3'd5);
                    d.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                end else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    d.legal = 1; d.alu = md_tab[f3];
`endif
                end
            end
            default: d.legal = 0;
        endcase
        return d;
    endfunction

    // Model state: the D slot and the instruction/pc now sitting in X
    logic        m_dv, m_xv;
    logic [31:0] m_di, m_dp, m_xi, m_xp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dv = 0; m_xv = 0; m_di = 0; m_dp = 0; m_xi = 0; m_xp = 0;
        end else begin
            logic ready;
            ready = !stall_i || !m_dv;
            if (flush_x) begin
                m_dv = 0; m_xv = 0;
            end else begin
                if (!stall_i) begin m_xv = m_dv; m_xi = m_di; m_xp = m_dp; end
                if (fetch_if.if_valid && ready) begin
                    m_dv = 1; m_di = fetch_if.if_inst; m_dp = fetch_if.if_pc;
                end else if (!stall_i) m_dv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            ref_t dd, xx;
            logic live;
            dd = ref_decode(m_di);
            xx = ref_decode(m_xi);
            live = m_dv && !flush_x && dd.legal;
            chk("if_ready", 32'(fetch_if.if_ready), 32'(!stall_i || !m_dv));
            if (m_dv) begin
                chk("rs1", 32'(rs1), 32'(m_di[19:15]));
                chk("rs2", 32'(rs2), 32'(m_di[24:20]));
                chk("rd", 32'(rd), 32'(m_di[11:7]));
            end
            chk("rs1_v", 32'(rs1_v), 32'(live && dd.r1 && m_di[19:15] != 0));
            chk("rs2_v", 32'(rs2_v), 32'(live && dd.r2 && m_di[24:20] != 0));
            chk("rdm_v", 32'(rdm_v), 32'(live && dd.wd && m_di[11:7] != 0));
            chk("rdx_v", 32'(rdx_v), 32'(live && dd.wd && dd.fast && m_di[11:7] != 0));
            chk("x_valid", 32'(x_valid), 32'(m_xv));
            if (m_xv) begin
                chk("x_pc", x_pc, m_xp);
                chk("x_imm", x_imm, xx.imm);
                chk("x_funct3", 32'(x_funct3), 32'(m_xi[14:12]));
                chk("x_illegal", 32'(x_illegal), 32'(!xx.legal));
                chk("x_is_load", 32'(x_is_load), 32'(xx.legal && xx.ld));
                chk("x_is_store", 32'(x_is_store), 32'(xx.legal && xx.st));
                chk("x_is_branch", 32'(x_is_branch), 32'(xx.legal && xx.br));
                chk("x_is_jal", 32'(x_is_jal), 32'(xx.legal && xx.jal));
                chk("x_is_jalr", 32'(x_is_jalr), 32'(xx.legal && xx.jalr));
                if (xx.legal) chk("x_alu_op", 32'(x_alu_op), 32'(xx.alu));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        fetch_if.if_valid = v;
        fetch_if.if_inst  = inst;
        fetch_if.if_pc    = pc;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op, f7;
        case ($urandom_range(0, 9))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;  4: op = 7'h63;
            5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;  8: op = 7'h33;
            default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, pick_reg(), pick_reg(), 3'($urandom), pick_reg(), op};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00700293;
    localparam logic [31:0] I_LW   = 32'h0042A303;
    localparam logic [31:0] I_MUL  = 32'h026283B3;
    localparam logic [31:0] I_BEQ  = 32'hFE628CE3;

    initial begin
        ref_t pin;
        rst_n = 1'b1; stall_i = 1'b0; flush_x = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_x_valid", 32'(x_valid), 32'd0);
        chk("reset_if_ready", 32'(fetch_if.if_ready), 32'd1);
        chk("reset_rdm_v", 32'(rdm_v), 32'd0);
        chk("reset_x_pc", x_pc, 32'd0);
        cmp_en = 1;

        pin = ref_decode(I_BEQ);
        chk("model_beq_imm", pin.imm, 32'hFFFFFFF8);
        pin = ref_decode(I_LW);
        chk("model_lw_imm", pin.imm, 32'h4);

        step(); step();
        rst_n = 1'b1;

        offer(1'b1, I_ADDI, 32'h100);
        step();
        #1;
        chk("addi_rd", 32'(rd), 32'd5);
        chk("addi_rs1_v", 32'(rs1_v), 32'd0);
        chk("addi_rs2_v", 32'(rs2_v), 32'd0);
        chk("addi_rdx_v", 32'(rdx_v), 32'd1);
        chk("addi_rdm_v", 32'(rdm_v), 32'd1);

        offer(1'b1, I_LW, 32'h104);
        step();
        #1;
        chk("addi_x_valid", 32'(x_valid), 32'd1);
        chk("addi_x_imm", x_imm, 32'h7);
        chk("lw_rs1", 32'(rs1), 32'd5);
        chk("lw_rs1_v", 32'(rs1_v), 32'd1);
        chk("lw_rdx_v", 32'(rdx_v), 32'd0);
        chk("lw_rdm_v", 32'(rdm_v), 32'd1);

        stall_i = 1'b1;
        offer(1'b1, I_MUL, 32'h108);
        #1;
        chk("stall_if_ready", 32'(fetch_if.if_ready), 32'd0);
        for (int s = 0; s < 2; s++) begin
            step();
            #1;
            chk("stall_rs1_held", 32'(rs1), 32'd5);
            chk("stall_x_imm_held", x_imm, 32'h7);
            chk("stall_x_pc_held", x_pc, 32'h100);
        end
        stall_i = 1'b0;
        step();
        #1;
        chk("lw_x_is_load", 32'(x_is_load), 32'd1);
        chk("lw_x_imm", x_imm, 32'h4);
        chk("lw_x_pc", x_pc, 32'h104);
`ifdef RV32M_EN
        chk("mul_rdm_v", 32'(rdm_v), 32'd1);
        chk("mul_rdx_v", 32'(rdx_v), 32'd0);
`else
        chk("mul_rdm_v", 32'(rdm_v), 32'd0);
        chk("mul_rs1_v", 32'(rs1_v), 32'd0);
        chk("mul_rs2_v", 32'(rs2_v), 32'd0);
        chk("mul_rdx_v", 32'(rdx_v), 32'd0);
`endif

        offer(1'b1, I_BEQ, 32'h10C);
        step();
        #1;
`ifdef RV32M_EN
        chk("mul_x_illegal", 32'(x_illegal), 32'd0);
`else
        chk("mul_x_illegal", 32'(x_illegal), 32'd1);
`endif
        chk("beq_rs1_v", 32'(rs1_v), 32'd1);
        chk("beq_rs2_v", 32'(rs2_v), 32'd1);
        chk("beq_rdm_v", 32'(rdm_v), 32'd0);

        offer(1'b0, 32'h0, 32'h0);
        step();
        #1;
        chk("beq_x_is_branch", 32'(x_is_branch), 32'd1);
        chk("beq_x_imm", x_imm, 32'hFFFFFFF8);

        offer(1'b1, I_ADDI, 32'h200);
        step();
        stall_i = 1'b1; flush_x = 1'b1;
        offer(1'b1, I_LW, 32'h204);
        step();
        stall_i = 1'b0; flush_x = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #1;
        chk("flush_x_valid", 32'(x_valid), 32'd0);
        chk("flush_d_empty_rdm_v", 32'(rdm_v), 32'd0);
        step();
        #1;
        chk("flush_dropped_x_valid", 32'(x_valid), 32'd0);

        for (int c = 0; c < 400; c++) begin
            step();
            if (c == 200) begin
                offer(1'b1, I_ADDI, 32'h300);
                rst_n = 1'b0;
                #1;
                chk("midreset_x_valid", 32'(x_valid), 32'd0);
                chk("midreset_if_ready", 32'(fetch_if.if_ready), 32'd1);
                chk("midreset_x_illegal", 32'(x_illegal), 32'd0);
            end else if (c == 203) begin
                rst_n = 1'b1;
            end
            offer($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC);
            stall_i = ($urandom_range(0, 3) == 0);
            flush_x = ($urandom_range(0, 9) == 0);
        end
        step();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
